core_lsu_axi: RTL and testbench

// - Parametrised AXI4-Lite load/store unit for the RV32I core's data-memory port; successor to the single-beat MEM-stage master.
// - Accepts one LB/LBU/LH/LHU/LW/SB/SH/SW request per transaction from the pipeline.
// - Generates byte strobes, lane-shifts store data, lane-extracts and sign/zero-extends load data.
// - Runs a proper AW/W/B and AR/R FSM and returns a one-cycle response pulse with an error code.

---
 rtl/core_lsu_axi_if.sv | 39 +++
 rtl/core_lsu_axi.sv | 176 +++++++++++++++++
 tb/tb_core_lsu_axi.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_lsu_axi_if.sv
// AXI4-Lite bus bundle between the load/store unit (master) and data memory (slave).
interface core_lsu_axi_if #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
);
  logic [AXI_AWIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [AXI_DWIDTH-1:0]   WDATA;
  logic [AXI_DWIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [AXI_AWIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [AXI_DWIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/core_lsu_axi.sv
// AXI4-Lite load/store unit for the RV32I data port: strobes, lane shifting, load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: report misaligned H/W accesses instead of silently aligning.
module core_lsu_axi #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_STORE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_ERR,
  core_lsu_axi_if.master axi
);
  // state       | meaning
  // IDLE        | ready for a new request
  // WADDR_DATA  | AW and W offered, each dropped after its own handshake
  // WRESP       | waiting for write response
  // RADDR       | AR offered
  // RDATA       | waiting for read data
  // RESP        | one-cycle response pulse to the pipeline
  localparam int NB = AXI_DWIDTH / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR_DATA, S_WRESP, S_RADDR, S_RDATA, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [AXI_AWIDTH-1:0] awaddr_q, araddr_q;
  logic [AXI_DWIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic                  aw_done, w_done;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [LW-1:0]         lane_q;
  logic [31:0]           rsp_rdata_q;
  logic [1:0]            rsp_err_q;

  logic [AXI_AWIDTH-1:0] req_addr_t, req_addr_al, req_beat;
  logic                  req_byte, req_half, req_trap;
  logic [LW-1:0]         req_lane;
  logic [NB-1:0]         req_mask;
  logic [AXI_DWIDTH-1:0] req_wdata_rep;
  logic                  accept, aw_hs, w_hs;
  logic [AXI_DWIDTH-1:0] rd_shift;
  logic [31:0]           rd_ext;

  always_comb begin
    req_byte    = (REQ_SIZE == 2'b00);
    req_half    = (REQ_SIZE == 2'b01);
    req_addr_t  = REQ_ADDR[AXI_AWIDTH-1:0];
    req_addr_al = req_addr_t;
    // natural alignment also guarantees no access straddles a bus beat
    if (req_half)
      req_addr_al[0] = 1'b0;
    else if (!req_byte)
      req_addr_al[1:0] = 2'b00;
    req_beat      = {req_addr_al[AXI_AWIDTH-1:LW], {LW{1'b0}}};
    req_lane      = req_addr_al[LW-1:0];
    req_mask      = req_byte ? NB'(1) : (req_half ? NB'(3) : NB'(15));
    req_wdata_rep = {(AXI_DWIDTH/32){REQ_WDATA}};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_trap = req_half ? req_addr_t[0] : (!req_byte && (req_addr_t[1:0] != 2'b00));
  end
`else
  assign req_trap = 1'b0;
`endif

  assign accept = REQ_VALID && (state == S_IDLE);
  assign aw_hs  = axi.AWVALID && axi.AWREADY;
  assign w_hs   = axi.WVALID && axi.WREADY;

  always_comb begin
    rd_shift = axi.RDATA >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   rd_ext = {{24{!uns_q && rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{16{!uns_q && rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift[31:0];
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (REQ_VALID) begin
          if (req_trap)       state_nxt = S_RESP;
          else if (REQ_STORE) state_nxt = S_WADDR_DATA;
          else                state_nxt = S_RADDR;
        end
      end
      S_WADDR_DATA: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WRESP;
      S_WRESP:      if (axi.BVALID)  state_nxt = S_RESP;
      S_RADDR:      if (axi.ARREADY) state_nxt = S_RDATA;
      S_RDATA:      if (axi.RVALID)  state_nxt = S_RESP;
      S_RESP:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY   = (state == S_IDLE);
    RSP_VALID   = (state == S_RESP);
    axi.AWVALID = (state == S_WADDR_DATA) && !aw_done;
    axi.WVALID  = (state == S_WADDR_DATA) && !w_done;
    axi.BREADY  = (state == S_WRESP);
    axi.ARVALID = (state == S_RADDR);
    axi.RREADY  = (state == S_RDATA);
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
    end else begin
      if (accept) begin
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        size_q      <= REQ_SIZE;
        uns_q       <= REQ_UNSIGNED;
        lane_q      <= req_lane;
        rsp_rdata_q <= '0;
        rsp_err_q   <= req_trap ? 2'b10 : 2'b00;
        if (!req_trap) begin
          if (REQ_STORE) begin
            awaddr_q <= req_beat;
            wstrb_q  <= req_mask << req_lane;
            wdata_q  <= req_wdata_rep << {req_lane, 3'b000};
          end else begin
            araddr_q <= req_beat;
          end
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if ((state == S_WRESP) && axi.BVALID)
        rsp_err_q <= (axi.BRESP != 2'b00) ? 2'b01 : 2'b00;
      if ((state == S_RDATA) && axi.RVALID) begin
        rsp_err_q   <= (axi.RRESP != 2'b00) ? 2'b01 : 2'b00;
        rsp_rdata_q <= (axi.RRESP != 2'b00) ? 32'h0 : rd_ext;
      end
    end
  end

  assign axi.AWADDR = awaddr_q;
  assign axi.ARADDR = araddr_q;
  assign axi.WDATA  = wdata_q;
  assign axi.WSTRB  = wstrb_q;
  assign RSP_RDATA  = rsp_rdata_q;
  assign RSP_ERR    = rsp_err_q;
endmodule

// File: tb/tb_core_lsu_axi.sv
// Directed bench for core_lsu_axi with a latency-programmable AXI4-Lite slave and a response scoreboard.
module tb_core_lsu_axi;
  logic        CLK = 1'b0;
  logic        NRST;
  logic        REQ_VALID, REQ_STORE, REQ_UNSIGNED;
  logic [1:0]  REQ_SIZE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        REQ_READY, RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_ERR;

  core_lsu_axi_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) axi ();

  core_lsu_axi #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .CLK(CLK), .NRST(NRST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_STORE(REQ_STORE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .axi(axi)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave knobs
  int         aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  logic [1:0] b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] rd_data = 32'h0;

  int   aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic aw_got, w_got, r_pend;
  logic s_aw_hs, s_w_hs, s_ar_hs;

  assign axi.AWREADY = (aw_lat == 0) || (axi.AWVALID && (aw_wait >= aw_lat));
  assign axi.WREADY  = (w_lat == 0)  || (axi.WVALID  && (w_wait  >= w_lat));
  assign axi.ARREADY = (ar_lat == 0) || (axi.ARVALID && (ar_wait >= ar_lat));
  assign s_aw_hs = axi.AWVALID && axi.AWREADY;
  assign s_w_hs  = axi.WVALID && axi.WREADY;
  assign s_ar_hs = axi.ARVALID && axi.ARREADY;

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      axi.BVALID <= 1'b0; axi.BRESP <= 2'b00;
      axi.RVALID <= 1'b0; axi.RRESP <= 2'b00; axi.RDATA <= 32'h0;
    end else begin
      aw_wait <= (axi.AWVALID && !axi.AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (axi.WVALID && !axi.WREADY) ? w_wait + 1 : 0;
      ar_wait <= (axi.ARVALID && !axi.ARREADY) ? ar_wait + 1 : 0;
      if (s_aw_hs) aw_got <= 1'b1;
      if (s_w_hs)  w_got  <= 1'b1;
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !axi.BVALID) begin
        if (b_wait >= b_lat) begin
          axi.BVALID <= 1'b1; axi.BRESP <= b_resp; b_wait <= 0;
        end else b_wait <= b_wait + 1;
      end
      if (axi.BVALID && axi.BREADY) begin
        axi.BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (s_ar_hs) r_pend <= 1'b1;
      if ((r_pend || s_ar_hs) && !axi.RVALID) begin
        if (r_wait >= r_lat) begin
          axi.RVALID <= 1'b1; axi.RDATA <= rd_data; axi.RRESP <= r_resp; r_wait <= 0;
        end else r_wait <= r_wait + 1;
      end
      if (axi.RVALID && axi.RREADY) begin
        axi.RVALID <= 1'b0; r_pend <= 1'b0;
      end
    end
  end

  // scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;   // accept cycle counted as 1; 0 = not checked
  } rsp_t;
  rsp_t        exp_rsp_q[$];
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];
  logic [35:0] exp_w_q[$];

  int cyc = 0, acc_cyc = 0, rsp_pulses = 0, b_hs = 0, arv_cycles = 0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (NRST === 1'b1) begin
      if (REQ_VALID && REQ_READY) acc_cyc = cyc;
      if (axi.ARVALID) arv_cycles++;
      if (axi.BVALID && axi.BREADY) b_hs++;
      if (axi.AWVALID && axi.AWREADY) begin
        check("aw_pending", exp_aw_q.size() != 0, 1);
        if (exp_aw_q.size() != 0) check("awaddr", axi.AWADDR, exp_aw_q.pop_front());
      end
      if (axi.WVALID && axi.WREADY) begin
        check("w_pending", exp_w_q.size() != 0, 1);
        if (exp_w_q.size() != 0) check("wstrb_wdata", {axi.WSTRB, axi.WDATA}, exp_w_q.pop_front());
      end
      if (axi.ARVALID && axi.ARREADY) begin
        check("ar_pending", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) check("araddr", axi.ARADDR, exp_ar_q.pop_front());
      end
      if (RSP_VALID) begin
        rsp_pulses++;
        check("rsp_pending", exp_rsp_q.size() != 0, 1);
        if (exp_rsp_q.size() != 0) begin
          rsp_t e;
          e = exp_rsp_q.pop_front();
          check("rsp_rdata", RSP_RDATA, e.rdata);
          check("rsp_err", RSP_ERR, e.err);
          if (e.lat != 0) check("rsp_latency", cyc - acc_cyc + 1, e.lat);
        end
      end
    end
  end

  task automatic push_rsp(input logic [31:0] rd, input logic [1:0] er, input int lat);
    rsp_t e;
    e.rdata = rd; e.err = er; e.lat = lat;
    exp_rsp_q.push_back(e);
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(posedge CLK); #1;
    REQ_STORE = st; REQ_SIZE = sz; REQ_UNSIGNED = un; REQ_ADDR = a; REQ_WDATA = wd;
    REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 50) begin @(posedge CLK); #1; n++; end
    check("req_ready", REQ_READY, 1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    // captured request must not follow later input changes
    REQ_STORE = 1'($urandom); REQ_SIZE = 2'($urandom); REQ_UNSIGNED = 1'($urandom);
    REQ_ADDR = $urandom; REQ_WDATA = $urandom;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_rsp_q.size() != 0 && n < 200) begin @(posedge CLK); #1; n++; end
    check("rsp_outstanding", exp_rsp_q.size(), 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int p0, b0, a0;
    NRST = 1'b0; REQ_VALID = 1'b0; REQ_STORE = 1'b0; REQ_SIZE = 2'b00;
    REQ_UNSIGNED = 1'b0; REQ_ADDR = 32'h0; REQ_WDATA = 32'h0;
    #12;
    check("rst_req_ready", REQ_READY, 1);
    check("rst_rsp", {RSP_VALID, RSP_RDATA, RSP_ERR}, 0);
    check("rst_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY}, 0);
    check("rst_bus", {axi.AWADDR, axi.ARADDR}, 0);
    check("rst_wbus", {axi.WSTRB, axi.WDATA}, 0);
    @(posedge CLK); #1 NRST = 1'b1;

    // SW, zero-wait slave
    exp_aw_q.push_back(32'h104); exp_w_q.push_back({4'hF, 32'hDEADBEEF});
    push_rsp(32'h0, 2'b00, 4);
    issue(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF);
    wait_rsp();

    // SB, WREADY three cycles ahead of AWREADY
    aw_lat = 3; w_lat = 0;
    b0 = b_hs;
    exp_aw_q.push_back(32'h100); exp_w_q.push_back({4'h8, 32'hA5000000});
    push_rsp(32'h0, 2'b00, 0);
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5);
    check("sb_both_valid", {axi.AWVALID, axi.WVALID}, 2'b11);
    @(posedge CLK); #1;
    check("sb_w_dropped_first", {axi.AWVALID, axi.WVALID}, 2'b10);
    wait_rsp();
    check("sb_single_b", b_hs - b0, 1);
    aw_lat = 0;

    // SH upper half
    exp_aw_q.push_back(32'h104); exp_w_q.push_back({4'hC, 32'h12340000});
    push_rsp(32'h0, 2'b00, 4);
    issue(1'b1, 2'b01, 1'b0, 32'h106, 32'h00001234);
    wait_rsp();

    // SW with slave error and delayed B
    b_resp = 2'b11; b_lat = 2;
    exp_aw_q.push_back(32'h108); exp_w_q.push_back({4'hF, 32'h11223344});
    push_rsp(32'h0, 2'b01, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h108, 32'h11223344);
    wait_rsp();
    b_resp = 2'b00; b_lat = 0;

    // byte / halfword loads from lane 2
    rd_data = 32'h00F30000;
    exp_ar_q.push_back(32'h100); push_rsp(32'hFFFFFFF3, 2'b00, 4);
    issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0);
    wait_rsp();
    exp_ar_q.push_back(32'h100); push_rsp(32'h000000F3, 2'b00, 4);
    issue(1'b0, 2'b00, 1'b1, 32'h102, 32'h0);
    wait_rsp();
    exp_ar_q.push_back(32'h100); push_rsp(32'h000000F3, 2'b00, 4);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    wait_rsp();
    rd_data = 32'h80010000;
    exp_ar_q.push_back(32'h100); push_rsp(32'hFFFF8001, 2'b00, 4);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    wait_rsp();
    exp_ar_q.push_back(32'h100); push_rsp(32'h00008001, 2'b00, 4);
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    wait_rsp();

    // reserved size behaves as word, slow AR
    rd_data = 32'hCAFEF00D; ar_lat = 2;
    exp_ar_q.push_back(32'h10C); push_rsp(32'hCAFEF00D, 2'b00, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h10C, 32'h0);
    wait_rsp();
    ar_lat = 0;

    // LW with RRESP error and late RVALID: one pulse, data zeroed
    rd_data = 32'h55AA55AA; r_resp = 2'b10; r_lat = 5;
    p0 = rsp_pulses;
    exp_ar_q.push_back(32'h200); push_rsp(32'h0, 2'b01, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    wait_rsp();
    repeat (3) @(posedge CLK);
    #1 check("lw_err_single_pulse", rsp_pulses - p0, 1);
    r_resp = 2'b00; r_lat = 0;

    // misaligned halfword load
    rd_data = 32'h1234ABCD;
    a0 = arv_cycles;
`ifdef LSU_MISALIGN_TRAP_EN
    push_rsp(32'h0, 2'b10, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    wait_rsp();
    check("trap_no_arvalid", arv_cycles - a0, 0);
`else
    exp_ar_q.push_back(32'h100); push_rsp(32'hFFFFABCD, 2'b00, 4);
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    wait_rsp();
    check("align_one_ar", arv_cycles - a0, 1);
`endif

    // reset while AW is stalled
    aw_lat = 1000;
    p0 = rsp_pulses;
    exp_aw_q.push_back(32'h300); exp_w_q.push_back({4'hF, 32'h0BADF00D});
    push_rsp(32'h0, 2'b00, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h0BADF00D);
    @(posedge CLK); #1;
    check("pre_rst_aw_stalled", {axi.AWVALID, axi.AWREADY}, 2'b10);
    #2 NRST = 1'b0;
    #1;
    check("rst_mid_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID, RSP_VALID}, 0);
    check("rst_mid_ready", REQ_READY, 1);
    exp_rsp_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    aw_lat = 0;
    repeat (2) @(posedge CLK);
    #1 NRST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check("rst_no_rsp", rsp_pulses - p0, 0);
    rd_data = 32'h76543210;
    exp_ar_q.push_back(32'h400); push_rsp(32'h76543210, 2'b00, 4);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    wait_rsp();

    check("aw_leftover", exp_aw_q.size(), 0);
    check("w_leftover", exp_w_q.size(), 0);
    check("ar_leftover", exp_ar_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
